// File: rtl/irq_ctrl_if.sv
// Interrupt interface between peripheral sources/register block and the controller.
// Latency: none. This file only bundles the wires.
// Backpressure: none. Requests are held until irq_ack; ack is a one-cycle pulse.
// Ports:   irq_sources - level per source
//          irq_mask    - per-source enable
//          irq_ack     - acknowledge pulse
//          irq_out     - request to the CPU
//          active_id   - presented index, 3'h7 = none
//          pending     - pending register
// Modports: master = sources/register block side; slave = controller side.
interface irq_ctrl_if #(
    parameter int NUM_IRQS = 4
);
    logic [NUM_IRQS-1:0] irq_sources;
    logic [NUM_IRQS-1:0] irq_mask;
    logic                irq_ack;
    logic                irq_out;
    logic [2:0]          active_id;
    logic [NUM_IRQS-1:0] pending;

    modport master (
        output irq_sources,
        output irq_mask,
        output irq_ack,
        input  irq_out,
        input  active_id,
        input  pending
    );

    modport slave (
        input  irq_sources,
        input  irq_mask,
        input  irq_ack,
        output irq_out,
        output active_id,
        output pending
    );
endinterface

// File: rtl/irq_ctrl.sv
// Edge-capturing, fixed-priority (lowest index wins) interrupt controller with ack handshake.
// Latency: source edge to irq_out is 2 cycles; with IRQ_CTRL_SYNC_EN defined it is 4 cycles.
// Backpressure: the request and active_id are held until irq_ack; one GAP cycle follows each ack.
// Ports: clk, rst_n (async, active-low); bus (irq_ctrl_if.slave): irq_sources, irq_mask,
//        irq_ack in; irq_out, active_id (3'h7 = none), pending out.
// Option: `define IRQ_CTRL_SYNC_EN adds a 2-flop synchronizer ahead of the edge detector.
module irq_ctrl #(
    parameter int NUM_IRQS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    irq_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

    localparam logic [2:0] NO_IRQ = 3'h7;

    state_t              state_q, state_d;
    logic                irq_out_q, irq_out_d;
    logic [2:0]          active_id_q, active_id_d;
    logic [NUM_IRQS-1:0] pending_q, pending_d;
    logic [NUM_IRQS-1:0] src_in, src_q, rise, elig, act_sel, clr;
    logic [2:0]          sel_id;
    logic                act_en;

`ifdef IRQ_CTRL_SYNC_EN
    logic [NUM_IRQS-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.irq_sources;
            sync2_q <= sync1_q;
        end
    end

    assign src_in = sync2_q;
`else
    assign src_in = bus.irq_sources;
`endif

    // src_q resets to 0 so a source already high at reset release counts as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) src_q <= '0;
        else        src_q <= src_in;
    end

    assign rise = src_in & ~src_q;
    assign elig = pending_q & bus.irq_mask;

    always_comb begin
        sel_id  = NO_IRQ;
        act_sel = '0;
        // Descending scan so the lowest eligible index is the last one written.
        for (int i = NUM_IRQS - 1; i >= 0; i--) begin
            if (elig[i]) sel_id = 3'(i);
        end
        // One-hot of the presented source; all-zero when nothing is presented.
        for (int i = 0; i < NUM_IRQS; i++) begin
            if (active_id_q == 3'(i)) act_sel[i] = 1'b1;
        end
        act_en = |(act_sel & bus.irq_mask);
    end

    always_comb begin
        state_d     = state_q;
        irq_out_d   = irq_out_q;
        active_id_d = active_id_q;
        clr         = '0;
        case (state_q)
            IDLE: begin
                irq_out_d   = 1'b0;
                active_id_d = NO_IRQ;
                if (|elig) begin
                    state_d     = ASSERT;
                    irq_out_d   = 1'b1;
                    active_id_d = sel_id;
                end
            end
            ASSERT: begin
                // Ack takes precedence over a simultaneous mask withdrawal.
                if (bus.irq_ack) begin
                    clr         = act_sel;
                    state_d     = GAP;
                    irq_out_d   = 1'b0;
                    active_id_d = NO_IRQ;
                end else if (!act_en) begin
                    state_d     = IDLE;
                    irq_out_d   = 1'b0;
                    active_id_d = NO_IRQ;
                end
            end
            GAP: begin
                state_d     = IDLE;
                irq_out_d   = 1'b0;
                active_id_d = NO_IRQ;
            end
            default: begin
                state_d     = IDLE;
                irq_out_d   = 1'b0;
                active_id_d = NO_IRQ;
            end
        endcase
        // A fresh edge in the clearing cycle keeps the bit set.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            irq_out_q   <= 1'b0;
            active_id_q <= NO_IRQ;
            pending_q   <= '0;
        end else begin
            state_q     <= state_d;
            irq_out_q   <= irq_out_d;
            active_id_q <= active_id_d;
            pending_q   <= pending_d;
        end
    end

    assign bus.irq_out   = irq_out_q;
    assign bus.active_id = active_id_q;
    assign bus.pending   = pending_q;
endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;
`ifdef IRQ_CTRL_SYNC_EN
    localparam int SE = 2;
`else
    localparam int SE = 0;
`endif

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    irq_ctrl_if #(.NUM_IRQS(4)) bus ();

    irq_ctrl #(.NUM_IRQS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle pulse on the sources and wait until pending reflects it.
    task automatic pulse(input logic [3:0] s);
        bus.irq_sources = s;
        tick();
        bus.irq_sources = 4'b0000;
        repeat (SE) tick();
    endtask

    task automatic ack();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.irq_sources = 4'b0000;
        bus.irq_mask    = 4'hF;
        bus.irq_ack     = 1'b0;
        repeat (3) tick();
        chk("rst_irq_out", {7'd0, bus.irq_out}, 8'h00);
        chk("rst_active_id", {5'd0, bus.active_id}, 8'h07);
        chk("rst_pending", {4'd0, bus.pending}, 8'h00);
        rst_n = 1'b1;
        tick();

        // Single source 2: pending after 1 cycle, request after 2.
        pulse(4'b0100);
        chk("s1_pending", {4'd0, bus.pending}, 8'h04);
        chk("s1_irq_out_early", {7'd0, bus.irq_out}, 8'h00);
        tick();
        chk("s1_irq_out", {7'd0, bus.irq_out}, 8'h01);
        chk("s1_active_id", {5'd0, bus.active_id}, 8'h02);
        tick();
        chk("s1_hold_id", {5'd0, bus.active_id}, 8'h02);
        ack();
        chk("s1_gap_irq_out", {7'd0, bus.irq_out}, 8'h00);
        chk("s1_gap_id", {5'd0, bus.active_id}, 8'h07);
        chk("s1_cleared", {4'd0, bus.pending}, 8'h00);
        tick();
        tick();
        chk("s1_idle_irq_out", {7'd0, bus.irq_out}, 8'h00);

        // Sources 1 and 3 together: 1 first, then 3 two cycles after the ack.
        pulse(4'b1010);
        chk("s2_pending", {4'd0, bus.pending}, 8'h0A);
        tick();
        chk("s2_first_id", {5'd0, bus.active_id}, 8'h01);
        ack();
        chk("s2_pend_after_ack", {4'd0, bus.pending}, 8'h08);
        chk("s2_gap", {7'd0, bus.irq_out}, 8'h00);
        tick();
        chk("s2_idle", {7'd0, bus.irq_out}, 8'h00);
        tick();
        chk("s2_second_out", {7'd0, bus.irq_out}, 8'h01);
        chk("s2_second_id", {5'd0, bus.active_id}, 8'h03);
        ack();
        tick();
        tick();

        // No preemption: source 0 arrives while 2 is presented.
        pulse(4'b0100);
        tick();
        chk("s3_id2", {5'd0, bus.active_id}, 8'h02);
        pulse(4'b0001);
        chk("s3_pending", {4'd0, bus.pending}, 8'h05);
        chk("s3_no_preempt", {5'd0, bus.active_id}, 8'h02);
        tick();
        chk("s3_still_2", {5'd0, bus.active_id}, 8'h02);
        ack();
        chk("s3_pend_after_ack", {4'd0, bus.pending}, 8'h01);
        tick();
        tick();
        chk("s3_then_0_out", {7'd0, bus.irq_out}, 8'h01);
        chk("s3_then_0_id", {5'd0, bus.active_id}, 8'h00);
        ack();
        tick();
        tick();

        // Masked source still captured, presented one cycle after unmasking.
        bus.irq_mask = 4'b1110;
        pulse(4'b0001);
        chk("s4_pending", {4'd0, bus.pending}, 8'h01);
        tick();
        chk("s4_masked_out", {7'd0, bus.irq_out}, 8'h00);
        bus.irq_mask = 4'b1111;
        tick();
        chk("s4_unmask_out", {7'd0, bus.irq_out}, 8'h01);
        chk("s4_unmask_id", {5'd0, bus.active_id}, 8'h00);

        // Withdrawal keeps the pending bit.
        bus.irq_mask = 4'b1110;
        tick();
        chk("s5_wd_out", {7'd0, bus.irq_out}, 8'h00);
        chk("s5_wd_id", {5'd0, bus.active_id}, 8'h07);
        chk("s5_wd_pending", {4'd0, bus.pending}, 8'h01);
        bus.irq_mask = 4'b1111;
        tick();
        chk("s5_reassert", {7'd0, bus.irq_out}, 8'h01);

        // Re-edge on source 0 in the ack cycle: set wins over clear.
        bus.irq_sources = 4'b0001;
        repeat (SE) tick();
        ack();
        bus.irq_sources = 4'b0000;
        chk("s6_set_wins", {4'd0, bus.pending}, 8'h01);
        chk("s6_gap", {7'd0, bus.irq_out}, 8'h00);
        tick();
        tick();
        chk("s6_represent_id", {5'd0, bus.active_id}, 8'h00);
        ack();
        chk("s6_cleared", {4'd0, bus.pending}, 8'h00);
        tick();
        tick();

        // Ack in IDLE is ignored.
        bus.irq_mask = 4'b0000;
        pulse(4'b0010);
        tick();
        chk("s7_pending", {4'd0, bus.pending}, 8'h02);
        ack();
        chk("s7_idle_ack_pending", {4'd0, bus.pending}, 8'h02);
        chk("s7_idle_ack_out", {7'd0, bus.irq_out}, 8'h00);

        // Ack beats a simultaneous mask drop.
        bus.irq_mask = 4'b1111;
        tick();
        chk("s8_id1", {5'd0, bus.active_id}, 8'h01);
        bus.irq_mask = 4'b1101;
        ack();
        chk("s8_ack_wins", {4'd0, bus.pending}, 8'h00);
        chk("s8_out", {7'd0, bus.irq_out}, 8'h00);
        bus.irq_mask = 4'b1111;
        tick();
        tick();

        // Asynchronous reset mid-ASSERT.
        pulse(4'b1000);
        tick();
        chk("s9_pre_out", {7'd0, bus.irq_out}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("s9_rst_out", {7'd0, bus.irq_out}, 8'h00);
        chk("s9_rst_id", {5'd0, bus.active_id}, 8'h07);
        chk("s9_rst_pending", {4'd0, bus.pending}, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
